// File: rtl/fifo_write_ctrl_if.sv
// Write-side controller bus: producer/read-side requests, the pointer
// from the write counter, and the controller's strobes and occupancy flags.
interface fifo_write_ctrl_if #(
   parameter int FIFO_ADDRESS_SIZE = 2
) ();

   logic                         wr_req;
   logic                         rd_en;
   logic                         ovf_clr;
   logic [FIFO_ADDRESS_SIZE:0]   w_ptr;
   logic                         cw_en;
   logic                         mem_we;
   logic [FIFO_ADDRESS_SIZE-1:0] mem_waddr;
   logic [FIFO_ADDRESS_SIZE:0]   count;
   logic                         full;
   logic                         almost_full;
   logic                         empty;
   logic                         overflow;

   // Producer / environment side
   modport master (
      output wr_req, rd_en, ovf_clr, w_ptr,
      input  cw_en, mem_we, mem_waddr, count, full, almost_full, empty, overflow
   );

   // Controller side
   modport slave (
      input  wr_req, rd_en, ovf_clr, w_ptr,
      output cw_en, mem_we, mem_waddr, count, full, almost_full, empty, overflow
   );

endinterface

// File: rtl/fifo_write_ctrl.sv
// FIFO write-side controller: gates writes against the registered full flag,
// tracks occupancy with a saturating count and a three-state occupancy FSM,
// and keeps a sticky overflow flag for writes refused while full.
module fifo_write_ctrl #(
   parameter int MEMORY_DEPTH      = 4,
   parameter int FIFO_ADDRESS_SIZE = $clog2(MEMORY_DEPTH),
   parameter int ALMOST_FULL_LEVEL = MEMORY_DEPTH - 1
) (
   input  logic               clk,
   input  logic               rst_n,
   fifo_write_ctrl_if.slave   bus
);

   localparam int CW = FIFO_ADDRESS_SIZE + 1;
   localparam logic [CW-1:0] ZERO     = '0;
   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [CW-1:0] DEPTH_M1 = CW'(MEMORY_DEPTH - 1);
   localparam logic [CW-1:0] AF_LVL   = CW'(ALMOST_FULL_LEVEL);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_PART  = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          almost_full_q, almost_full_d;
   logic          overflow_q, overflow_d;

   logic          wr_acc;
   logic          rd_acc;
   logic          ovf_set;

   // Accept decisions; rst_n gating keeps the strobes low while held in reset
   assign wr_acc  = bus.wr_req & ~full_q & rst_n;
   assign rd_acc  = bus.rd_en & ~empty_q;
   assign ovf_set = bus.wr_req & full_q;

   assign bus.cw_en       = wr_acc;
   assign bus.mem_we      = wr_acc;
   assign bus.mem_waddr   = bus.w_ptr[FIFO_ADDRESS_SIZE-1:0];
   assign bus.count       = count_q;
   assign bus.full        = full_q;
   assign bus.empty       = empty_q;
   assign bus.almost_full = almost_full_q;
   assign bus.overflow    = overflow_q;

   // Next occupancy, FSM state, decoded flags and sticky overflow
   always_comb begin
      count_d = count_q;
      state_d = state_q;

      if (wr_acc && !rd_acc) begin
         count_d = count_q + ONE;
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - ONE;
      end

      case (state_q)
         S_EMPTY: if (wr_acc) state_d = S_PART;
         S_PART: begin
            if (wr_acc && !rd_acc && (count_q == DEPTH_M1)) begin
               state_d = S_FULL;
            end else if (rd_acc && !wr_acc && (count_q == ONE)) begin
               state_d = S_EMPTY;
            end
         end
         S_FULL:  if (rd_acc) state_d = S_PART;
         default: state_d = S_EMPTY;
      endcase

      empty_d       = (state_d == S_EMPTY);
      full_d        = (state_d == S_FULL);
      almost_full_d = (count_d >= AF_LVL);

      // A refused write outranks a simultaneous clear
      if (ovf_set) begin
         overflow_d = 1'b1;
      end else if (bus.ovf_clr) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // State and registered flags; reset discards all occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_EMPTY;
         count_q       <= ZERO;
         empty_q       <= 1'b1;
         full_q        <= 1'b0;
         almost_full_q <= (ZERO >= AF_LVL);
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         empty_q       <= empty_d;
         full_q        <= full_d;
         almost_full_q <= almost_full_d;
         overflow_q    <= overflow_d;
      end
   end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Bench for fifo_write_ctrl (depth 4, almost-full level 3): directed vector
// table, asynchronous reset checks and a randomized run against an
// occupancy-count reference model.
module tb_fifo_write_ctrl;

   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int AFL   = 3;

   logic clk;
   logic rst_n;

   fifo_write_ctrl_if #(.FIFO_ADDRESS_SIZE(AW)) bus ();

   fifo_write_ctrl #(
      .MEMORY_DEPTH      (DEPTH),
      .FIFO_ADDRESS_SIZE (AW),
      .ALMOST_FULL_LEVEL (AFL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit wr;
      bit rd;
      bit clr;
      bit cw;
      int cnt;
      bit full;
      bit af;
      bit empty;
      bit ovf;
   } vec_t;

   vec_t vecs[$];

   // Reference model state
   int          m_count;
   bit          m_ovf;
   logic [AW:0] m_ptr;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input bit wr, input bit rd, input bit clr);
      bus.wr_req  = wr;
      bus.rd_en   = rd;
      bus.ovf_clr = clr;
      bus.w_ptr   = m_ptr;
   endtask

   // One model-checked cycle: combinational strobes before the edge,
   // registered state after it.
   task automatic cycle(input bit wr, input bit rd, input bit clr);
      bit was_full, acc_w, acc_r;
      drive(wr, rd, clr);
      #1;
      was_full = (m_count == DEPTH);
      acc_w    = wr && !was_full;
      acc_r    = rd && (m_count != 0);
      chk("cw_en", 32'(bus.cw_en), 32'(acc_w));
      chk("mem_we", 32'(bus.mem_we), 32'(acc_w));
      chk("mem_waddr", 32'(bus.mem_waddr), 32'(m_ptr[AW-1:0]));
      @(posedge clk);
      m_count = m_count + int'(acc_w) - int'(acc_r);
      if (wr && was_full) m_ovf = 1'b1;
      else if (clr)       m_ovf = 1'b0;
      if (acc_w) m_ptr = m_ptr + 1'b1;
      #1;
      chk("count", 32'(bus.count), 32'(m_count));
      chk("full", 32'(bus.full), 32'(m_count == DEPTH));
      chk("empty", 32'(bus.empty), 32'(m_count == 0));
      chk("almost_full", 32'(bus.almost_full), 32'(m_count >= AFL));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
   endtask

   // Pulse reset between edges and verify the immediate clear
   task automatic async_reset();
      bus.wr_req = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst count", 32'(bus.count), 32'd0);
      chk("rst empty", 32'(bus.empty), 32'd1);
      chk("rst full", 32'(bus.full), 32'd0);
      chk("rst almost_full", 32'(bus.almost_full), 32'd0);
      chk("rst overflow", 32'(bus.overflow), 32'd0);
      chk("rst cw_en", 32'(bus.cw_en), 32'd0);
      chk("rst mem_we", 32'(bus.mem_we), 32'd0);
      bus.wr_req = 1'b0;
      #1 rst_n = 1'b1;
      m_count = 0;
      m_ovf   = 1'b0;
      m_ptr   = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // wr rd clr | cw count full af empty ovf
      vecs.push_back('{1,0,0, 1,1,0,0,0,0});
      vecs.push_back('{1,0,0, 1,2,0,0,0,0});
      vecs.push_back('{1,0,0, 1,3,0,1,0,0});
      vecs.push_back('{1,0,0, 1,4,1,1,0,0});
      vecs.push_back('{1,1,0, 0,3,0,1,0,1});
      vecs.push_back('{0,1,0, 0,2,0,0,0,1});
      for (int i = 0; i < 5; i++) vecs.push_back('{1,1,0, 1,2,0,0,0,1});
      vecs.push_back('{0,0,1, 0,2,0,0,0,0});
      vecs.push_back('{0,1,0, 0,1,0,0,0,0});
      vecs.push_back('{0,1,0, 0,0,0,0,1,0});
      for (int i = 0; i < 3; i++) vecs.push_back('{0,1,0, 0,0,0,0,1,0});
      vecs.push_back('{1,1,0, 1,1,0,0,0,0});
      vecs.push_back('{1,0,0, 1,2,0,0,0,0});
      vecs.push_back('{1,0,0, 1,3,0,1,0,0});
      vecs.push_back('{1,0,0, 1,4,1,1,0,0});
      vecs.push_back('{1,0,0, 0,4,1,1,0,1});
      vecs.push_back('{1,0,1, 0,4,1,1,0,1});
      vecs.push_back('{0,0,1, 0,4,1,1,0,0});
      vecs.push_back('{0,1,0, 0,3,0,1,0,0});

      rst_n = 1'b0;
      m_count = 0;
      m_ovf   = 1'b0;
      m_ptr   = '0;
      drive(1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      bus.wr_req = 1'b1;
      #1;
      chk("reset cw_en", 32'(bus.cw_en), 32'd0);
      chk("reset mem_we", 32'(bus.mem_we), 32'd0);
      chk("reset count", 32'(bus.count), 32'd0);
      chk("reset empty", 32'(bus.empty), 32'd1);
      chk("reset full", 32'(bus.full), 32'd0);
      chk("reset almost_full", 32'(bus.almost_full), 32'd0);
      chk("reset overflow", 32'(bus.overflow), 32'd0);
      bus.wr_req = 1'b0;
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vector table
      foreach (vecs[i]) begin
         drive(vecs[i].wr, vecs[i].rd, vecs[i].clr);
         #1;
         chk($sformatf("v%0d cw_en", i), 32'(bus.cw_en), 32'(vecs[i].cw));
         chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 32'(vecs[i].cw));
         chk($sformatf("v%0d mem_waddr", i), 32'(bus.mem_waddr), 32'(m_ptr[AW-1:0]));
         @(posedge clk);
         if (vecs[i].cw) m_ptr = m_ptr + 1'b1;
         #1;
         chk($sformatf("v%0d count", i), 32'(bus.count), 32'(vecs[i].cnt));
         chk($sformatf("v%0d full", i), 32'(bus.full), 32'(vecs[i].full));
         chk($sformatf("v%0d almost_full", i), 32'(bus.almost_full), 32'(vecs[i].af));
         chk($sformatf("v%0d empty", i), 32'(bus.empty), 32'(vecs[i].empty));
         chk($sformatf("v%0d overflow", i), 32'(bus.overflow), 32'(vecs[i].ovf));
      end

      // Count is 3 here: asynchronous reset mid-operation
      async_reset();

      // First operation after reset starts from empty
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);

      // Randomized run, alternating write-heavy and read-heavy phases
      for (int i = 0; i < 600; i++) begin
         int wb, rb;
         bit wr, rd, clr;
         wb  = ((i / 40) % 2 == 0) ? 75 : 30;
         rb  = ((i / 40) % 2 == 0) ? 30 : 75;
         wr  = ($urandom_range(0, 99) < wb);
         rd  = ($urandom_range(0, 99) < rb);
         clr = ($urandom_range(0, 99) < 10);
         cycle(wr, rd, clr);
         if (i == 300) async_reset();
      end

      drive(1'b0, 1'b0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
